// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- hazard control for a 5-stage in-order pipeline.
//
// The block detects load-use hazards and taken branches and drives the
// fetch/decode stall and decode/execute flush controls. It also selects
// ALU operand forwarding sources from the memory and writeback stages.
//
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   A1_D, A2_D               decode-stage source register addresses
//   A3_E, RF_WE_E,           execute-stage destination, write enable and
//   WBSelect_E               load marker (1 = result comes from memory)
//   A3_M, RF_WE_M            memory-stage destination / write enable
//   A3_W, RF_WE_W            writeback-stage destination / write enable
//   BranchTaken_E            branch resolved taken in execute
//   StallF, StallD           hold the PC / IF-ID register
//   FlushD, FlushE           clear the IF-ID / ID-EX register
//   FwdA_E, FwdB_E           operand select: 00 RF, 01 WB, 10 MEM
//   State_o                  FSM state: 00 RUN, 01 LDSTALL, 10 BRFLUSH
//
// Optional build macro HAZ_PERF_CNT_EN adds saturating 16-bit event
// counters StallCount_o (LDSTALL entries) and FlushCount_o (BRFLUSH entries).

module pipe_hazard_ctrl (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] A1_D,
   input  logic [3:0] A2_D,
   input  logic [3:0] A3_E,
   input  logic       RF_WE_E,
   input  logic       WBSelect_E,
   input  logic [3:0] A3_M,
   input  logic       RF_WE_M,
   input  logic [3:0] A3_W,
   input  logic       RF_WE_W,
   input  logic       BranchTaken_E,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE,
   output logic [1:0] FwdA_E,
   output logic [1:0] FwdB_E,
   output logic [1:0] State_o
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [15:0] StallCount_o,
   output logic [15:0] FlushCount_o
`endif
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      LDSTALL = 2'b01,
      BRFLUSH = 2'b10
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   state_t     state, nxt;
   logic       load_use;
   logic       stall_f, stall_d, flush_d, flush_e;
   logic [3:0] a1_e, a2_e;
   logic       vld_e;

   assign load_use = RF_WE_E & WBSelect_E & ((A3_E == A1_D) | (A3_E == A2_D));

   // ---------------- FSM ----------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= RUN;
      else     state <= nxt;
   end

   always_comb begin
      nxt     = RUN;
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      case (state)
         RUN: begin
            // A taken branch discards the decode instruction, so it
            // overrides any load-use stall on that same instruction.
            if (BranchTaken_E) begin
               flush_d = 1'b1;
               flush_e = 1'b1;
               nxt     = BRFLUSH;
            end else if (load_use) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
               nxt     = LDSTALL;
            end
         end
         LDSTALL: nxt = BranchTaken_E ? BRFLUSH : RUN;
         // Decode holds a wrong-path instruction here, so any hazard it
         // appears to raise is irrelevant.
         BRFLUSH: begin
            flush_d = 1'b1;
            nxt     = RUN;
         end
         default: nxt = RUN;   // illegal 11 recovers to RUN
      endcase
   end

   // Outputs are forced low while reset is held, independent of inputs.
   assign StallF  = stall_f & ~RST;
   assign StallD  = stall_d & ~RST;
   assign FlushD  = flush_d & ~RST;
   assign FlushE  = flush_e & ~RST;
   assign State_o = state;

   // ---------------- ID/EX source addresses ----------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         a1_e  <= 4'h0;
         a2_e  <= 4'h0;
         vld_e <= 1'b0;
      end else if (flush_e) begin
         a1_e  <= 4'h0;
         a2_e  <= 4'h0;
         vld_e <= 1'b0;
      end else begin
         a1_e  <= A1_D;
         a2_e  <= A2_D;
         vld_e <= 1'b1;
      end
   end

   // ---------------- forwarding ----------------
   // Memory stage holds the younger result, so it wins over writeback.
   always_comb begin
      FwdA_E = FWD_RF;
      if (vld_e && RF_WE_M && (A3_M == a1_e))      FwdA_E = FWD_MEM;
      else if (vld_e && RF_WE_W && (A3_W == a1_e)) FwdA_E = FWD_WB;
   end

   always_comb begin
      FwdB_E = FWD_RF;
      if (vld_e && RF_WE_M && (A3_M == a2_e))      FwdB_E = FWD_MEM;
      else if (vld_e && RF_WE_W && (A3_W == a2_e)) FwdB_E = FWD_WB;
   end

`ifdef HAZ_PERF_CNT_EN
   // ---------------- event counters ----------------
   logic [15:0] stall_cnt, flush_cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_cnt <= 16'h0;
         flush_cnt <= 16'h0;
      end else begin
         if (nxt == LDSTALL && state != LDSTALL && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'h1;
         if (nxt == BRFLUSH && state != BRFLUSH && flush_cnt != 16'hFFFF)
            flush_cnt <= flush_cnt + 16'h1;
      end
   end

   assign StallCount_o = stall_cnt;
   assign FlushCount_o = flush_cnt;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as listed below.
REQ-002 CLK  in  1  rising-edge clock.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 A1_D, A2_D  in  4 each  source register addresses in decode.
REQ-005 A3_E  in  4  destination register address in execute.
REQ-006 RF_WE_E, WBSelect_E  in  1 each  execute write enable; WBSelect_E=1 marks a memory-load result.
REQ-007 A3_M, RF_WE_M  in  4/1  memory-stage destination and write enable.
REQ-008 A3_W, RF_WE_W  in  4/1  writeback-stage destination and write enable.
REQ-009 BranchTaken_E  in  1  branch resolved taken in execute.
REQ-010 StallF, StallD  out  1 each  hold the fetch register / IF-ID register.
REQ-011 FlushD, FlushE  out  1 each  clear the IF-ID register / ID-EX register (drives its RST).
REQ-012 FwdA_E, FwdB_E  out  2 each  ALU operand forward select: 00 register file, 01 writeback, 10 memory.
REQ-013 State_o  out  2  current FSM state: 00 RUN, 01 LDSTALL, 10 BRFLUSH.

Function
REQ-014 The FSM SHALL have three states (RUN, LDSTALL, BRFLUSH); the encoding 11 is illegal and SHALL return to RUN on the next edge.
REQ-015 A load-use hazard SHALL exist when RF_WE_E=1, WBSelect_E=1, and A3_E equals A1_D or A2_D.
REQ-016 In RUN with a load-use hazard and BranchTaken_E=0, the block SHALL assert StallF=StallD=FlushE=1 combinationally in that cycle and go to LDSTALL.
REQ-017 LDSTALL SHALL last exactly one cycle with all stall/flush outputs 0, then return to RUN, or go to BRFLUSH if BranchTaken_E=1.
REQ-018 When BranchTaken_E=1, the block SHALL assert FlushD=FlushE=1 in that cycle and go to BRFLUSH.
REQ-019 BranchTaken_E SHALL take priority over a simultaneous load-use hazard, with StallF=StallD=0.
REQ-020 BRFLUSH SHALL assert FlushD=1 for one cycle, then go to RUN.
REQ-021 A load-use hazard detected in BRFLUSH SHALL be ignored, because the decode instruction is being flushed.
REQ-022 Internal registers A1_E/A2_E SHALL capture A1_D/A2_D on every edge, and SHALL capture 0 with a valid bit of 0 when FlushE=1.
REQ-023 FwdA_E SHALL be 10 if the valid bit is 1, RF_WE_M=1 and A3_M==A1_E.
REQ-024 Otherwise FwdA_E SHALL be 01 if the valid bit is 1, RF_WE_W=1 and A3_W==A1_E.
REQ-025 Otherwise FwdA_E SHALL be 00; FwdB_E SHALL follow the same rules using A2_E.
REQ-026 When memory and writeback both match, the memory stage SHALL win.
REQ-027 Stall and flush outputs SHALL be combinational from the current state and inputs; forward selects SHALL be combinational from registered addresses and M/W inputs.

Reset
REQ-028 While RST=1, the FSM SHALL be in RUN, A1_E=A2_E=0, the valid bit SHALL be 0, and all outputs SHALL be 0.
REQ-029 Reset asserted mid-LDSTALL or mid-BRFLUSH SHALL abort the sequence immediately, asynchronously.
REQ-030 The first edge after RST deasserts SHALL evaluate the inputs from the RUN state.

Configuration
REQ-031 With macro HAZ_PERF_CNT_EN defined, the block SHALL add outputs StallCount_o[15:0] and FlushCount_o[15:0].
REQ-032 StallCount_o SHALL increment once per entry into LDSTALL and saturate at 16'hFFFF; it SHALL reset to 0.
REQ-033 FlushCount_o SHALL increment once per entry into BRFLUSH and saturate at 16'hFFFF; it SHALL reset to 0.
REQ-034 Without HAZ_PERF_CNT_EN, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Load-use: A3_E=4'h3, RF_WE_E=1, WBSelect_E=1, A2_D=4'h3 -> StallF=StallD=FlushE=1 for exactly one cycle, State_o=01 the next cycle, then 00.
REQ-036 Branch: BranchTaken_E=1 for one cycle -> FlushD=FlushE=1 in that cycle, then FlushD=1 only for one cycle, then all 0.
REQ-037 Simultaneous events: load-use hazard plus BranchTaken_E=1 -> StallF=StallD=0, FlushD=FlushE=1, next State_o=10.
REQ-038 Forwarding priority: A1_E=5, A3_M=5, RF_WE_M=1, A3_W=5, RF_WE_W=1 -> FwdA_E=10; with RF_WE_M=0 -> FwdA_E=01.
REQ-039 Reset mid-operation: RST pulsed during BRFLUSH, between clock edges -> State_o=00 and all outputs 0 without waiting for CLK.
REQ-040 With HAZ_PERF_CNT_EN: 3 load-use events and 2 branches -> StallCount_o=3, FlushCount_o=2; forced near saturation, the counters hold at 16'hFFFF.
